// File: rtl/booth_mult_seq_pkg.sv
// Shared types for booth_mult_seq: FSM state encoding and radix-2 Booth recoding.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10
  } booth_op_t;

  // {Q[0], q_1}: 01 adds M, 10 subtracts M, 00/11 leave the partial product alone.
  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_PASS;
    endcase
  endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Operand/result handshake bundle for booth_mult_seq; master drives requests, slave is the multiplier.
interface booth_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             cancel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] product_lo;
  logic [WIDTH-1:0] product_hi;
  logic             ovf;

  modport master (
    output in_valid, multiplicand, multiplier, cancel, out_ready,
    input  in_ready, out_valid, product_lo, product_hi, ovf
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, cancel, out_ready,
    output in_ready, out_valid, product_lo, product_hi, ovf
  );
endinterface

// File: rtl/booth_mult_seq_booth_step.sv
// One radix-2 Booth iteration around the external adder: selects the adder operand
// and forms the sign-corrected arithmetic right shift of the partial sum.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] adder_sum,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_cin,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q1_next
);

  booth_op_t op;
  logic      v;
  logic      s;

  always_comb begin
    op        = booth_decode(q[0], q_1);
    adder_b   = '0;
    adder_cin = 1'b0;
    case (op)
      OP_ADD: adder_b = m;
      OP_SUB: begin
        adder_b   = ~m;
        adder_cin = 1'b1;
      end
      default: ;
    endcase
  end

  // The adder drops the carry out, so the true sign of the W+1-bit sum is recovered
  // from the overflow flag; this keeps M = most-negative exact.
  assign v = (a[WIDTH-1] == adder_b[WIDTH-1]) && (adder_sum[WIDTH-1] != a[WIDTH-1]);
  assign s = adder_sum[WIDTH-1] ^ v;

  assign {a_next, q_next, q1_next} = {s, adder_sum, q};

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed radix-2 Booth multiplier driving a shared external combinational adder.
// Optional MULT_OVF_EN builds the "product does not fit in WIDTH signed bits" flag.
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  booth_mult_seq_if.slave  bus,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_cin,
  input  logic [WIDTH-1:0] adder_sum
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, q_reg, m_reg;
  logic             q1_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] step_b, a_next, q_next;
  logic             step_cin, q1_next;
  logic             last_iter;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .q         (q_reg),
    .q_1       (q1_reg),
    .m         (m_reg),
    .a         (a_reg),
    .adder_sum (adder_sum),
    .adder_b   (step_b),
    .adder_cin (step_cin),
    .a_next    (a_next),
    .q_next    (q_next),
    .q1_next   (q1_next)
  );

  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // cancel outranks the final-iteration hand-off to DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.in_valid) state_next = RUN;
      RUN: begin
        if (bus.cancel)     state_next = IDLE;
        else if (last_iter) state_next = DONE;
      end
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_reg   <= '0;
      q_reg   <= '0;
      m_reg   <= '0;
      q1_reg  <= 1'b0;
      cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (bus.in_valid) begin
          m_reg   <= bus.multiplicand;
          q_reg   <= bus.multiplier;
          a_reg   <= '0;
          q1_reg  <= 1'b0;
          cnt_reg <= '0;
        end
        RUN: if (!bus.cancel) begin
          a_reg   <= a_next;
          q_reg   <= q_next;
          q1_reg  <= q1_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // The shared adder sees zeros whenever this block is not using it.
  assign adder_a   = (state_reg == RUN) ? a_reg    : '0;
  assign adder_b   = (state_reg == RUN) ? step_b   : '0;
  assign adder_cin = (state_reg == RUN) ? step_cin : 1'b0;

  assign bus.in_ready   = (state_reg == IDLE);
  assign bus.out_valid  = (state_reg == DONE);
  assign bus.product_hi = (state_reg == DONE) ? a_reg : '0;
  assign bus.product_lo = (state_reg == DONE) ? q_reg : '0;

`ifdef MULT_OVF_EN
  logic ovf_reg;
  logic ovf_calc;

  assign ovf_calc = (a_next != {WIDTH{q_next[WIDTH-1]}});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == RUN && state_next == DONE) begin
      ovf_reg <= ovf_calc;
    end
  end

  assign bus.ovf = (state_reg == DONE) & ovf_reg;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule
